ahb_line_fill: RTL and testbench

AHB_LINE_FILL -- requirements
Module: ahb_line_fill

---
 rtl/cache_pkg.sv | 14 +
 rtl/ahb_line_fill.sv | 81 ++++++++
 tb/tb_ahb_line_fill.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: line geometry, AHB-Lite encodings and line-fill FSM states shared by the fill engine
package cache_pkg;
   localparam int CACHE_LINE = 128;
   localparam int BEATS      = CACHE_LINE / 32;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   typedef enum logic [2:0] {IDLE, ADDR, BURST, ERR, DONE} fill_state_t;
endpackage

// File: rtl/ahb_line_fill.sv
// ahb_line_fill: AHB-Lite read master fetching one cache line as a pipelined INCR4 word burst
//   clk, rst           : clock, asynchronous active-low reset
//   mem_addr, mem_req  : line request from the cache; address latched only in IDLE
//   mem_data_out       : assembled line; a word changes only when its data beat is captured
//   mem_ready, mem_err : one-cycle completion pulse; mem_err marks a fill ended by AHB ERROR
//   HADDR..HWRITE      : AHB-Lite master address/control outputs (read-only master)
//   HRDATA/HREADY/HRESP: AHB-Lite slave response inputs
module ahb_line_fill #(
   parameter int CACHE_LINE = cache_pkg::CACHE_LINE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mem_addr,
   input  logic                  mem_req,
   output logic [CACHE_LINE-1:0] mem_data_out,
   output logic                  mem_ready,
   output logic                  mem_err,
   output logic [31:0]           HADDR,
   output logic [1:0]            HTRANS,
   output logic [2:0]            HBURST,
   output logic [2:0]            HSIZE,
   output logic                  HWRITE,
   input  logic [31:0]           HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);
   import cache_pkg::*;
   fill_state_t state, state_nxt;
   logic [31:0] base;
   logic [2:0]  addr_cnt, data_cnt;
   logic        err_q, addr_act, pend, capture, unused;
   assign unused = ^mem_addr[3:0];
   // an address phase is live in ADDR and for the SEQ beats until all four are accepted
   assign addr_act = state == ADDR || (state == BURST && addr_cnt < 3'(BEATS));
   // every accepted address owes exactly one data phase
   assign pend     = data_cnt < addr_cnt;
   assign capture  = state == BURST && HREADY && pend;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = mem_req ? ADDR : IDLE;
         ADDR:    state_nxt = HREADY ? BURST : ADDR;
         // first ERROR cycle (HREADY low) abandons the remaining beats
         BURST:   state_nxt = (pend && !HREADY && HRESP == HRESP_ERROR) ? ERR :
                              (capture && data_cnt == 3'(BEATS - 1)) ? DONE : BURST;
         ERR:     state_nxt = HREADY ? DONE : ERR;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      HTRANS    = state == ADDR ? HTRANS_NONSEQ : addr_act ? HTRANS_SEQ : HTRANS_IDLE;
      HADDR     = addr_act ? {base[31:4], addr_cnt[1:0], 2'b00} : 32'h0;
      HBURST    = addr_act ? HBURST_INCR4 : HBURST_SINGLE;
      HSIZE     = HSIZE_WORD;
      HWRITE    = 1'b0;
      mem_ready = state == DONE;
      mem_err   = state == DONE && err_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         base         <= '0;
         addr_cnt     <= '0;
         data_cnt     <= '0;
         err_q        <= 1'b0;
         mem_data_out <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && mem_req) begin
            base     <= {mem_addr[31:4], 4'b0000};
            addr_cnt <= '0;
            data_cnt <= '0;
         end
         if (addr_act && HREADY) addr_cnt <= addr_cnt + 3'd1;
         if (capture) begin
            mem_data_out[{data_cnt[1:0], 5'b00000} +: 32] <= HRDATA;
            data_cnt <= data_cnt + 3'd1;
         end
         if (state_nxt == DONE) err_q <= state == ERR;
      end
   end
endmodule

// File: tb/tb_ahb_line_fill.sv
// tb_ahb_line_fill: randomized bench with a wait/error-capable AHB slave and a line-level reference model
module tb_ahb_line_fill;
   logic         clk = 1'b0, rst = 1'b0;
   logic [31:0]  mem_addr = '0;
   logic         mem_req = 1'b0;
   logic [127:0] mem_data_out;
   logic         mem_ready, mem_err;
   logic [31:0]  HADDR, HRDATA;
   logic [1:0]   HTRANS;
   logic [2:0]   HBURST, HSIZE;
   logic         HWRITE, HREADY, HRESP;
   int n_cmp = 0, n_bad = 0;

   ahb_line_fill dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_err(mem_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 clk = ~clk;

   // slave configuration for the current fill: data per beat, wait states per beat, erroring beat (-1 none)
   logic [31:0]  s_data [4];
   int           s_wait [4];
   int           s_err = -1;
   // observations
   int           gcyc = 0, acc_n = 0, viol = 0, ready_cnt = 0, ready_cyc = 0, t0 = 0, first = 0;
   logic         err_seen = 1'b0;
   logic [127:0] data_seen = '0, line = '0;
   logic [31:0]  acc_addr [$];
   logic [1:0]   acc_trans [$];
   // slave private state
   bit           dph = 0, p_stall = 0, p_err = 0;
   int           db = 0, wl = 0, es = 0;
   logic [1:0]   p_trans = '0;
   logic [31:0]  p_addr = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      acc_addr.delete();
      acc_trans.delete();
      acc_n = 0;
      viol = 0;
      ready_cnt = 0;
   endtask

   // slave + protocol monitor, sampling one time unit after each rising edge
   initial begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      forever begin
         @(posedge clk);
         #1;
         gcyc++;
         if (!rst) begin
            dph = 0; es = 0; p_stall = 0; p_err = 0;
         end
         if (p_stall && !p_err && (HTRANS !== p_trans || HADDR !== p_addr)) viol++;
         if (p_err && HTRANS !== 2'b00) viol++;
         if (mem_ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = gcyc;
            err_seen  = mem_err;
            data_seen = mem_data_out;
            if (HTRANS !== 2'b00) viol++;
         end
         HRDATA = $urandom;
         if (!dph) begin
            HREADY = 1'b1; HRESP = 1'b0;
         end else if (wl > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; wl--;
         end else if (db == s_err && es == 0) begin
            HREADY = 1'b0; HRESP = 1'b1; es = 1;
         end else if (db == s_err) begin
            HREADY = 1'b1; HRESP = 1'b1; es = 0; dph = 0;
         end else begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = s_data[db]; dph = 0;
         end
         if (HREADY && HTRANS[1] === 1'b1) begin
            acc_addr.push_back(HADDR);
            acc_trans.push_back(HTRANS);
            dph = 1;
            db = acc_n % 4;
            wl = s_wait[db];
            acc_n++;
         end
         p_stall = !HREADY && HTRANS[1] === 1'b1;
         p_err   = !HREADY && HRESP;
         p_trans = HTRANS;
         p_addr  = HADDR;
      end
   end

   // one request; expectations come from the beat/wait/error rules, not from the DUT
   task automatic fill(input string tag, input logic [31:0] a, input int hold, input bit scramble);
      logic [127:0] exp;
      logic [31:0]  b;
      int last, lat, nacc, start;
      exp  = line;
      b    = {a[31:4], 4'h0};
      last = s_err < 0 ? 3 : s_err;
      nacc = s_err < 0 ? 4 : s_err + 1;
      lat  = 2;
      for (int k = 0; k < last; k++) begin
         exp[32*k +: 32] = s_data[k];
         lat += s_wait[k] + 1;
      end
      if (s_err < 0) exp[96 +: 32] = s_data[3];
      lat += s_wait[last] + (s_err < 0 ? 1 : 2);
      @(negedge clk);
      clear_logs();
      mem_addr = a;
      mem_req  = 1'b1;
      start    = gcyc;
      for (int i = 0; i < 100 && ready_cnt == 0; i++) begin
         @(negedge clk);
         if (gcyc - start >= hold || ready_cnt > 0) mem_req = 1'b0;
         if (scramble) mem_addr = $urandom;
      end
      mem_req = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, " pulses"}, 128'(ready_cnt), 128'(1));
      check({tag, " latency"}, 128'(ready_cyc - start), 128'(lat));
      check({tag, " err"}, 128'(err_seen), 128'(s_err >= 0));
      check({tag, " line"}, data_seen, exp);
      check({tag, " held"}, mem_data_out, exp);
      check({tag, " beats"}, 128'(acc_addr.size()), 128'(nacc));
      for (int k = 0; k < acc_addr.size() && k < 4; k++) begin
         check($sformatf("%s haddr%0d", tag, k), 128'(acc_addr[k]), 128'(b + 32'(4 * k)));
         check($sformatf("%s htrans%0d", tag, k), 128'(acc_trans[k]), 128'(k == 0 ? 2'b10 : 2'b11));
      end
      check({tag, " protocol"}, 128'(viol), 128'(0));
      line = exp;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " htrans"}, 128'(HTRANS), 128'(2'b00));
      check({tag, " haddr"}, 128'(HADDR), 128'(0));
      check({tag, " hburst"}, 128'(HBURST), 128'(3'b000));
      check({tag, " hsize"}, 128'(HSIZE), 128'(3'b010));
      check({tag, " hwrite"}, 128'(HWRITE), 128'(0));
      check({tag, " ready"}, 128'(mem_ready), 128'(0));
      check({tag, " err"}, 128'(mem_err), 128'(0));
      check({tag, " data"}, mem_data_out, 128'(0));
   endtask

   initial begin
      int nonseq;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;

      s_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      s_wait = '{0, 0, 0, 0};
      s_err  = -1;
      fill("zero_wait", 32'h0000_1234, 1, 0);
      check("zero_wait exact", line, 128'h000000A3_000000A2_000000A1_000000A0);

      s_wait = '{0, 0, 2, 0};
      fill("wait_b2", 32'h0000_1234, 1, 0);

      s_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      s_wait = '{0, 0, 0, 0};
      s_err  = 1;
      fill("err_b1", 32'h0000_1234, 1, 0);
      check("err_b1 exact", line, 128'h000000A3_000000A2_000000A1_000000B0);

      s_err  = -1;
      s_data = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
      @(negedge clk);
      clear_logs();
      mem_addr = 32'h80;
      mem_req  = 1'b1;
      t0       = gcyc;
      for (int i = 0; i < 20 && gcyc - t0 < 4; i++) @(negedge clk);
      mem_req = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      line = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      s_data = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      fill("after_rst", 32'h0000_0040, 1, 0);

      s_data = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
      @(negedge clk);
      clear_logs();
      mem_addr = 32'h100;
      mem_req  = 1'b1;
      @(negedge clk);
      mem_addr = 32'h300;
      for (int i = 0; i < 100 && ready_cnt < 1; i++) @(negedge clk);
      mem_addr = 32'h200;
      first = ready_cyc;
      for (int i = 0; i < 100 && ready_cnt < 2; i++) @(negedge clk);
      mem_req = 1'b0;
      repeat (3) @(negedge clk);
      nonseq = 0;
      foreach (acc_trans[k]) if (acc_trans[k] == 2'b10) nonseq++;
      check("req_held pulses", 128'(ready_cnt), 128'(2));
      check("req_held spacing", 128'(ready_cyc - first), 128'(7));
      check("req_held beats", 128'(acc_addr.size()), 128'(8));
      check("req_held nonseq", 128'(nonseq), 128'(2));
      check("req_held addr0", 128'(acc_addr.size() > 0 ? acc_addr[0] : 32'hx), 128'(32'h100));
      check("req_held addr4", 128'(acc_addr.size() > 4 ? acc_addr[4] : 32'hx), 128'(32'h200));
      check("req_held protocol", 128'(viol), 128'(0));
      line = {s_data[3], s_data[2], s_data[1], s_data[0]};
      check("req_held line", mem_data_out, line);

      s_data = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
      fill("drop_req", 32'h0000_2000, 2, 0);

      repeat (25) begin
         foreach (s_data[k]) s_data[k] = $urandom;
         foreach (s_wait[k]) s_wait[k] = $urandom_range(0, 2);
         s_err = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : -1;
         fill("rand", $urandom, int'($urandom_range(1, 8)), 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
